mmss_timer_ctrl: RTL and testbench
==================================

# mmss_timer_ctrl

Run/pause/set controller for a four-digit BCD minutes:seconds timer (00:00–59:59) built from cascaded mod-10/mod-6 digit counters. It divides the system clock to a one-second tick, sequences digit increments and carries, and handles the set-time mode from debounced one-cycle button pulses. It sits between the button conditioning logic and the seven-segment display driver.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick; legal range ≥ 2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: reset; synchronous, active-low. One clock; reset is synchronous and active-low.
- `btn_start` input 1: one-cycle pulse; toggles between IDLE and RUN.
- `btn_mode` input 1: one-cycle pulse; steps through the set modes.
- `btn_inc` input 1: one-cycle pulse; increments the field being set.
- `btn_clr` input 1: one-cycle pulse; zeroes the time.
- `sec_lo` output 4: seconds units, BCD 0–9.
- `sec_hi` output 4: seconds tens, BCD 0–5.
- `min_lo` output 4: minutes units, BCD 0–9.
- `min_hi` output 4: minutes tens, BCD 0–5.
- `state` output 2: IDLE=0, RUN=1, SET_MIN=2, SET_SEC=3.
- `rollover` output 1: one-cycle pulse on the 59:59→00:00 wrap.

## Operation
- Reset (rst_n=0 at an edge): all digits 0, state IDLE, prescaler 0, rollover 0.
- Button priority, evaluated per edge: clr > start > mode > inc. Only the highest-priority asserted button acts; the rest are dropped.
- clr, in any state: digits → 00:00, state → IDLE, prescaler → 0.
- IDLE: start → RUN; mode → SET_MIN; inc ignored.
- RUN: start → IDLE, with digits retained (pause); mode and inc ignored.
- SET_MIN: inc → minutes +1 mod 60 (09→10, 59→00), seconds untouched; mode → SET_SEC; start ignored.
- SET_SEC: inc → seconds +1 mod 60, with no carry into minutes; mode → IDLE; start ignored.
- Prescaler: held at 0 in every state except RUN. In RUN it counts 0..TICK_DIV-1 and wraps to 0. The tick is the edge at which the prescaler equals TICK_DIV-1.
- On a tick, the time advances one second:
  - sec_lo 9→0 carries into sec_hi.
  - sec_hi 5→0 carries into min_lo.
  - min_lo 9→0 carries into min_hi.
  - min_hi 5→0 means 59:59→00:00 and sets rollover=1 for the following cycle.
- A tick and a start pulse on the same edge: the time advances and the state goes to IDLE.
- A tick and clr on the same edge: clr wins; no advance and no rollover.
- Pausing discards the partial second, because the prescaler is cleared.

## Timing
- All outputs are registered. State and digits reflect the button sampled at edge k from edge k onward.
- With start sampled at edge 0, the first second advance happens at edge TICK_DIV. Each later advance follows every TICK_DIV edges.
- In SET_MIN/SET_SEC, each inc pulse changes the digits at the same edge. Back-to-back inc pulses on consecutive cycles each count.
- rollover is high exactly one cycle, the cycle after the wrap edge; otherwise 0.
- Digits never hold non-BCD values, and sec_hi/min_hi never exceed 5.

## Structure
- Shared package `timer_pkg`:
  - state enum: IDLE, RUN, SET_MIN, SET_SEC.
  - BCD limit constants: DIG_MAX_LO=9, DIG_MAX_HI=5.
- Sub-module `bcd_digit`:
  - parameter MOD (10 or 6).
  - inputs clk, rst_n, clr, inc.
  - outputs digit[3:0] (registered) and co (combinational: inc && digit==MOD-1).
  - Four instances are chained through co.
  - In set modes, the controller drives the inc of the lo digit for the selected field and masks the carry out of the hi digit.
- Prescaler width is $clog2(TICK_DIV).

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold rst_n=0 for 2 cycles → digits 00:00, state=0, rollover=0. Then release with no buttons for 20 cycles → outputs unchanged.
- Run: start pulse at edge 0 → state=1. sec_lo=1 at edge 4 and 2 at edge 8. Start pulse at edge 10 → state=0, time 00:02 held. A second start → the next advance comes 4 edges later.
- Set and wrap: from IDLE, pulse mode, then inc ×59 → 59:00. Pulse mode, then inc ×59 → 59:59. Then:
  - One more inc → 59:00, with no minute carry.
  - Re-set the seconds to 59, pulse mode (→ IDLE), then start.
  - After 4 edges → 00:00 and rollover=1 for exactly one cycle.
- Priority: start and clr in the same cycle while in RUN at 00:07 → 00:00, IDLE. mode and inc in the same cycle in SET_MIN → state SET_SEC, minutes unchanged.
- Tick/start collision: start pulse on the tick edge → time advances by 1 and state=IDLE.
- Reset mid-RUN: at 03:17 in RUN, rst_n=0 for one edge → 00:00, IDLE; no rollover pulse.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and constants for the mm:ss timer controller.
//                - state_e   : controller state encoding (IDLE/RUN/SET_MIN/SET_SEC)
//                - DIG_MAX_* : largest legal value of a units / tens BCD digit
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  localparam int DIG_MAX_LO = 9;
  localparam int DIG_MAX_HI = 5;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/mmss_timer_ctrl_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD counter digit counting 0..MOD-1 and wrapping to 0.
//                Digits are chained through co_o to form a multi-digit counter.
//  Ports       : clk       - system clock, rising edge
//                rst_n     - synchronous active-low reset
//                clr_i     - synchronous clear to 0 (dominates inc_i)
//                inc_i     - advance the digit by one
//                digit_o   - registered digit value
//                co_o      - carry out: inc_i while the digit is at MOD-1
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] digit_o,
  output logic       co_o
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       at_last;

  assign at_last = (digit_q == LAST);

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = 4'd0;
    end else if (inc_i) begin
      digit_d = at_last ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign co_o    = inc_i && at_last;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/mmss_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmss_timer_ctrl
//  Description : Run/pause/set controller for a BCD mm:ss timer (00:00-59:59).
//                Divides clk to a one-second tick, cascades four BCD digits
//                and implements the set-minutes / set-seconds modes driven
//                by debounced single-cycle button pulses.
//  Ports       : clk          - system clock, rising edge
//                rst_n        - synchronous active-low reset
//                btn_start_i  - toggle IDLE <-> RUN
//                btn_mode_i   - step IDLE -> SET_MIN -> SET_SEC -> IDLE
//                btn_inc_i    - increment the field being set
//                btn_clr_i    - zero the time, return to IDLE
//                sec_lo_o     - seconds units (0-9)
//                sec_hi_o     - seconds tens  (0-5)
//                min_lo_o     - minutes units (0-9)
//                min_hi_o     - minutes tens  (0-5)
//                state_o      - IDLE=0 RUN=1 SET_MIN=2 SET_SEC=3
//                rollover_o   - one-cycle pulse after the 59:59 -> 00:00 wrap
//  Revision    : 1.0 - initial release
// ============================================================================
module mmss_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_clr_i,
  output logic [3:0] sec_lo_o,
  output logic [3:0] sec_hi_o,
  output logic [3:0] min_lo_o,
  output logic [3:0] min_hi_o,
  output logic [1:0] state_o,
  output logic       rollover_o
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  state_e         state_q;
  state_e         state_d;
  logic [PW-1:0]  presc_q;
  logic [PW-1:0]  presc_d;
  logic           rollover_q;
  logic           rollover_d;

  // Prioritised button decode: only the highest-priority button acts.
  logic do_clr;
  logic do_start;
  logic do_mode;
  logic do_inc;

  assign do_clr   = btn_clr_i;
  assign do_start = btn_start_i && !btn_clr_i;
  assign do_mode  = btn_mode_i  && !btn_clr_i && !btn_start_i;
  assign do_inc   = btn_inc_i   && !btn_clr_i && !btn_start_i && !btn_mode_i;

  // A tick only advances time when clr is not also asserted.
  logic tick;
  logic tick_adv;

  assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign tick_adv = tick && !do_clr;

  // --------------------------------------------------------------------------
  // Next-state / prescaler logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (do_clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (do_start)     state_d = RUN;
          else if (do_mode) state_d = SET_MIN;
        end
        RUN: begin
          if (do_start)     state_d = IDLE;
        end
        SET_MIN: begin
          if (do_mode)      state_d = SET_SEC;
        end
        SET_SEC: begin
          if (do_mode)      state_d = IDLE;
        end
        default:            state_d = IDLE;
      endcase
    end
  end

  // The prescaler only runs while staying in RUN; leaving RUN (pause or clr)
  // clears it, which discards any partial second.
  always_comb begin
    presc_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Digit chain
  // --------------------------------------------------------------------------
  logic sec_lo_inc;
  logic sec_lo_co;
  logic sec_hi_co;
  logic min_lo_inc;
  logic min_lo_co;
  logic min_hi_co;

  assign sec_lo_inc = tick_adv || ((state_q == SET_SEC) && do_inc);

  // The seconds-tens carry only reaches the minutes while running, so
  // setting seconds wraps 59 -> 00 without touching the minutes.
  assign min_lo_inc = (sec_hi_co && tick_adv) || ((state_q == SET_MIN) && do_inc);

  // The minutes-tens carry is only a real 59:59 wrap when it comes from a tick.
  assign rollover_d = min_hi_co && tick_adv;

  bcd_digit #(.MOD(DIG_MAX_LO + 1)) u_sec_lo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (do_clr),
    .inc_i   (sec_lo_inc),
    .digit_o (sec_lo_o),
    .co_o    (sec_lo_co)
  );

  bcd_digit #(.MOD(DIG_MAX_HI + 1)) u_sec_hi (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (do_clr),
    .inc_i   (sec_lo_co),
    .digit_o (sec_hi_o),
    .co_o    (sec_hi_co)
  );

  bcd_digit #(.MOD(DIG_MAX_LO + 1)) u_min_lo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (do_clr),
    .inc_i   (min_lo_inc),
    .digit_o (min_lo_o),
    .co_o    (min_lo_co)
  );

  bcd_digit #(.MOD(DIG_MAX_HI + 1)) u_min_hi (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (do_clr),
    .inc_i   (min_lo_co),
    .digit_o (min_hi_o),
    .co_o    (min_hi_co)
  );

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      rollover_q <= rollover_d;
    end
  end

  assign state_o    = state_q;
  assign rollover_o = rollover_q;

endmodule : mmss_timer_ctrl
`default_nettype wire

// File: tb/tb_mmss_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmss_timer_ctrl
//  Description : Self-checking bench for mmss_timer_ctrl (TICK_DIV=4).
//                The reference model keeps the time as total seconds and
//                applies the button rules with plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmss_timer_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start_i;
  logic       btn_mode_i;
  logic       btn_inc_i;
  logic       btn_clr_i;
  logic [3:0] sec_lo_o;
  logic [3:0] sec_hi_o;
  logic [3:0] min_lo_o;
  logic [3:0] min_hi_o;
  logic [1:0] state_o;
  logic       rollover_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: total seconds, state number, prescaler count, pulse.
  int m_t    = 0;
  int m_st   = 0;
  int m_pre  = 0;
  int m_roll = 0;

  mmss_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start_i (btn_start_i),
    .btn_mode_i  (btn_mode_i),
    .btn_inc_i   (btn_inc_i),
    .btn_clr_i   (btn_clr_i),
    .sec_lo_o    (sec_lo_o),
    .sec_hi_o    (sec_hi_o),
    .min_lo_o    (min_lo_o),
    .min_hi_o    (min_hi_o),
    .state_o     (state_o),
    .rollover_o  (rollover_o)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int t);
    int mm;
    int ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_time();
    return {min_hi_o, min_lo_o, sec_hi_o, sec_lo_o};
  endfunction

  task automatic model_update(input logic s, input logic m, input logic i,
                              input logic c, input logic r);
    int  old;
    bit  adv;
    old = m_st;
    if (!r || c) begin
      m_t = 0; m_st = 0; m_pre = 0; m_roll = 0;
    end else begin
      adv    = (old == 1) && (m_pre == TD - 1);
      m_roll = (adv && m_t == 3599) ? 1 : 0;
      if (adv) m_t = (m_t + 1) % 3600;
      if (s) begin
        if (old == 0)      m_st = 1;
        else if (old == 1) m_st = 0;
      end else if (m) begin
        if (old == 0)      m_st = 2;
        else if (old == 2) m_st = 3;
        else if (old == 3) m_st = 0;
      end else if (i) begin
        if (old == 2)      m_t = (((m_t / 60) + 1) % 60) * 60 + (m_t % 60);
        else if (old == 3) m_t = (m_t / 60) * 60 + ((m_t % 60) + 1) % 60;
      end
      m_pre = (old == 1 && m_st == 1) ? (m_pre + 1) % TD : 0;
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare.
  task automatic step(input logic s, input logic m, input logic i,
                      input logic c, input logic r);
    btn_start_i = s;
    btn_mode_i  = m;
    btn_inc_i   = i;
    btn_clr_i   = c;
    rst_n       = r;
    @(posedge clk);
    model_update(s, m, i, c, r);
    #1;
    check_value("time",     32'(dut_time()), 32'(bcd_of(m_t)));
    check_value("state",    32'(state_o),    32'(m_st));
    check_value("rollover", 32'(rollover_o), 32'(m_roll));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 0, 1);
  endtask

  initial begin
    btn_start_i = 0; btn_mode_i = 0; btn_inc_i = 0; btn_clr_i = 0; rst_n = 0;

    // Reset and quiet period
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_value("rst_time",  32'(dut_time()), 32'h0000);
    check_value("rst_state", 32'(state_o),    32'd0);
    idle(20);
    check_value("quiet_time", 32'(dut_time()), 32'h0000);

    // Run: start at edge 0, advances at edges 4 and 8, pause at edge 10
    step(1, 0, 0, 0, 1);
    check_value("run_state", 32'(state_o), 32'd1);
    idle(3);
    check_value("run_e3", 32'(dut_time()), 32'h0000);
    idle(1);
    check_value("run_e4", 32'(dut_time()), 32'h0001);
    idle(4);
    check_value("run_e8", 32'(dut_time()), 32'h0002);
    idle(1);
    step(1, 0, 0, 0, 1);
    check_value("pause_state", 32'(state_o),    32'd0);
    check_value("pause_time",  32'(dut_time()), 32'h0002);
    step(1, 0, 0, 0, 1);
    idle(3);
    check_value("resume_e3", 32'(dut_time()), 32'h0002);
    idle(1);
    check_value("resume_e4", 32'(dut_time()), 32'h0003);

    // Set and wrap
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    incs(59);
    check_value("set_min59", 32'(dut_time()), 32'h5900);
    step(0, 1, 0, 0, 1);
    incs(59);
    check_value("set_sec59", 32'(dut_time()), 32'h5959);
    incs(1);
    check_value("sec_wrap_nocarry", 32'(dut_time()), 32'h5900);
    incs(59);
    step(0, 1, 0, 0, 1);
    check_value("back_idle", 32'(state_o), 32'd0);
    step(1, 0, 0, 0, 1);
    idle(4);
    check_value("wrap_time", 32'(dut_time()), 32'h0000);
    check_value("wrap_roll", 32'(rollover_o), 32'd1);
    idle(1);
    check_value("wrap_roll_off", 32'(rollover_o), 32'd0);

    // Priority: clr beats start while running at 00:07
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    idle(28);
    check_value("at_0007", 32'(dut_time()), 32'h0007);
    step(1, 0, 0, 1, 1);
    check_value("clr_start_time",  32'(dut_time()), 32'h0000);
    check_value("clr_start_state", 32'(state_o),    32'd0);
    // mode beats inc in SET_MIN
    step(0, 1, 0, 0, 1);
    incs(3);
    step(0, 1, 1, 0, 1);
    check_value("mode_inc_state", 32'(state_o),    32'd3);
    check_value("mode_inc_time",  32'(dut_time()), 32'h0300);

    // Tick/start collision
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    idle(3);
    step(1, 0, 0, 0, 1);
    check_value("coll_time",  32'(dut_time()), 32'h0001);
    check_value("coll_state", 32'(state_o),    32'd0);

    // Reset mid-run at 03:17
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    incs(3);
    step(0, 1, 0, 0, 1);
    incs(17);
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check_value("at_0317", 32'(dut_time()), 32'h0317);
    idle(2);
    step(0, 0, 0, 0, 0);
    check_value("mid_rst_time",  32'(dut_time()), 32'h0000);
    check_value("mid_rst_state", 32'(state_o),    32'd0);
    idle(1);
    check_value("mid_rst_roll", 32'(rollover_o), 32'd0);

    // Randomised traffic against the model
    for (int k = 0; k < 6000; k++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 3) == 0),  ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 499) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_mmss_timer_ctrl
`default_nettype wire
